// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package mdu_pkg;

    localparam int unsigned MDU_ITER = 32;

    typedef enum logic [1:0] {
        MDU_MULTU = 2'b00,
        MDU_MULT  = 2'b01,
        MDU_DIVU  = 2'b10,
        MDU_DIV   = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10
    } mdu_state_e;

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negate; used for operand magnitudes and result sign fix-up.
module mdu_sign_fix #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] val_i,
    input  logic         neg_i,
    output logic [W-1:0] val_o
);

    assign val_o = neg_i ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO, 33-cycle latency.
// Define MDU_DIV_EN to build the restoring divider; otherwise divide starts are ignored.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = MDU_ITER
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             HiWe,
    input  logic             LoWe,
    input  logic [WIDTH-1:0] WData,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             Busy,
    output logic             Done
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam int unsigned ACC_W = 2 * WIDTH;

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             neg_lo_q, neg_lo_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             busy_q, busy_d, done_q, done_d;

    logic             op_signed, op_div, start_ok, neg_a, neg_b;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   mul_sum;
    logic [ACC_W-1:0] mul_step, prod_fix;

    assign op_signed = (Op == MDU_MULT) || (Op == MDU_DIV);
    assign op_div    = (Op == MDU_DIVU) || (Op == MDU_DIV);
    assign neg_a     = op_signed & A[WIDTH-1];
    assign neg_b     = op_signed & B[WIDTH-1];

    mdu_sign_fix #(.W(WIDTH)) u_fix_a (.val_i(A), .neg_i(neg_a), .val_o(mag_a));
    mdu_sign_fix #(.W(WIDTH)) u_fix_b (.val_i(B), .neg_i(neg_b), .val_o(mag_b));

    // Shift-add: upper half accumulates multiplicand, multiplier shifts out of the low end
    assign mul_sum  = {1'b0, acc_q[ACC_W-1:WIDTH]}
                    + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    assign mul_step = {mul_sum, acc_q[WIDTH-1:1]};

    mdu_sign_fix #(.W(ACC_W)) u_fix_prod (.val_i(acc_q), .neg_i(neg_lo_q), .val_o(prod_fix));

`ifdef MDU_DIV_EN
    logic             div_q, div_d, neg_hi_q, neg_hi_d;
    logic [WIDTH:0]   rem_sh;
    logic             rem_ge;
    logic [WIDTH-1:0] rem_new, quot_fix, rem_fix;
    logic [ACC_W-1:0] div_step;

    assign start_ok = 1'b1;

    // Restoring step: acc holds {remainder, dividend/quotient}
    assign rem_sh   = acc_q[ACC_W-1:WIDTH-1];
    assign rem_ge   = rem_sh >= {1'b0, opnd_q};
    assign rem_new  = rem_ge ? WIDTH'(rem_sh - {1'b0, opnd_q}) : rem_sh[WIDTH-1:0];
    assign div_step = {rem_new, acc_q[WIDTH-2:0], rem_ge};

    mdu_sign_fix #(.W(WIDTH)) u_fix_quot (.val_i(acc_q[WIDTH-1:0]), .neg_i(neg_lo_q), .val_o(quot_fix));
    mdu_sign_fix #(.W(WIDTH)) u_fix_rem  (.val_i(acc_q[ACC_W-1:WIDTH]), .neg_i(neg_hi_q), .val_o(rem_fix));
`else
    assign start_ok = ~op_div;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            neg_lo_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef MDU_DIV_EN
            div_q    <= 1'b0;
            neg_hi_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            neg_lo_q <= neg_lo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef MDU_DIV_EN
            div_q    <= div_d;
            neg_hi_q <= neg_hi_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        neg_lo_d = neg_lo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
`ifdef MDU_DIV_EN
        div_d    = div_q;
        neg_hi_d = neg_hi_q;
`endif
        case (state_q)
            IDLE: begin
                if (HiWe) hi_d = WData;
                if (LoWe) lo_d = WData;
                if (Start && start_ok) begin
                    state_d  = RUN;
                    busy_d   = 1'b1;
                    cnt_d    = '0;
                    neg_lo_d = neg_a ^ neg_b;
                    acc_d    = {{WIDTH{1'b0}}, mag_b};
                    opnd_d   = mag_a;
`ifdef MDU_DIV_EN
                    div_d    = op_div;
                    neg_hi_d = neg_a;
                    if (op_div) begin
                        // Divide by zero keeps the all-ones quotient unsigned
                        neg_lo_d = (neg_a ^ neg_b) && (B != '0);
                        acc_d    = {{WIDTH{1'b0}}, mag_a};
                        opnd_d   = mag_b;
                    end
`endif
                end
            end
            RUN: begin
                acc_d = mul_step;
`ifdef MDU_DIV_EN
                if (div_q) acc_d = div_step;
`endif
                if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
                else                            cnt_d   = cnt_q + CNT_W'(1);
            end
            FIX: begin
                {hi_d, lo_d} = prod_fix;
`ifdef MDU_DIV_EN
                if (div_q) begin
                    hi_d = rem_fix;
                    lo_d = quot_fix;
                end
`endif
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign Hi   = hi_q;
    assign Lo   = lo_q;
    assign Busy = busy_q;
    assign Done = done_q;

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit for the MIPS datapath: executes MULT, MULTU, DIV and DIVU over 33 cycles, holds the architectural HI/LO registers, and services MTHI/MTLO. Hi and Lo feed inputs In2/In3 of the write-back 4:1 select (In0 = ALU result, In1 = memory data). Busy drives the hazard unit, which stalls MFHI/MFLO and any new multiply/divide.

## Interface
- WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- Start  in  1  launches the operation selected by Op; sampled only in IDLE.
- Op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- A  in  WIDTH  multiplicand / dividend (rs).
- B  in  WIDTH  multiplier / divisor (rt).
- HiWe  in  1  MTHI: Hi <= WData.
- LoWe  in  1  MTLO: Lo <= WData.
- WData  in  WIDTH  MTHI/MTLO data.
- Hi  out  WIDTH  HI register.
- Lo  out  WIDTH  LO register.
- Busy  out  1  operation in progress.
- Done  out  1  one-cycle pulse: Hi/Lo just updated by an operation.

## Operation
- FSM: IDLE, RUN, FIX.
- IDLE: Start=1 at edge E0 latches Op, sign flags, operand magnitudes (two's-complement negate when signed and bit WIDTH-1 set), clears the iteration counter, enters RUN, and sets Busy=1.
- RUN: one iteration per edge for WIDTH edges (E1..E32). Multiply uses shift-add on a 2*WIDTH accumulator. Divide is restoring: shift the remainder left, subtract the divisor, keep the result if non-negative, and set the quotient bit. The counter reaching WIDTH-1 moves the FSM to FIX.
- FIX (edge E33): apply signs and write Hi/Lo. Busy goes to 0 and Done goes to 1 for exactly one cycle. Return to IDLE.
- Multiply: {Hi,Lo} = 64-bit product. MULT negates the product if sign(A)^sign(B).
- Divide: Lo = quotient, Hi = remainder. DIV negates the quotient if sign(A)^sign(B) and gives the remainder the sign of A.
- Divide by zero, B=0: Hi = A and Lo = all ones, for both DIV and DIVU. The operation still takes the full latency.
- DIV of 0x80000000 by 0xFFFFFFFF: Lo = 0x80000000, Hi = 0. This falls out of the magnitude arithmetic and needs no special case.
- Start while Busy=1 is ignored, with no queuing.
- HiWe/LoWe while Busy=1 are dropped.
- HiWe/LoWe in IDLE take effect at that edge. If Start is also asserted on that edge, it is accepted too, and the operation result overwrites Hi/Lo at E33.
- Invalid-free encoding: all four Op values are legal.

## Timing
- Reset values: Hi=0, Lo=0, Busy=0, Done=0, FSM=IDLE, counter=0.
- Reset asserted mid-operation aborts immediately. Hi/Lo return to 0 and no Done is produced.
- Latency: Start sampled at E0, result visible after E33, Busy high for 33 cycles.
- Back-to-back operation: Start may be asserted in the cycle Done=1, since the FSM is already in IDLE.
- Hi, Lo, Busy and Done are all registered, with no combinational input-to-output path.

## Configuration
- MDU_DIV_EN defined: full behaviour as above.
- MDU_DIV_EN undefined: the divider datapath is removed. Start with Op=10/11 is ignored: Busy stays 0, Done never pulses, and Hi/Lo are unchanged. Multiply and MTHI/MTLO are unaffected.

## Structure
- Package mdu_pkg holds:
  - Op encodings MDU_MULTU, MDU_MULT, MDU_DIVU, MDU_DIV;
  - the FSM state typedef (IDLE/RUN/FIX);
  - MDU_ITER = 32.
- Sub-module mdu_sign_fix: combinational conditional two's-complement negate, parameterised by width. It is instantiated for operand magnitudes, the 64-bit product, the quotient and the remainder.
- The write-back 4:1 select stays outside this block.

## Test plan
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> after E33, Hi=0xFFFFFFFE, Lo=0x00000001, Done=1 for one cycle, Busy=1 for 33 cycles.
- MULT A=0xFFFFFFFD (-3), B=7 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFEB (-21).
- DIV A=0xFFFFFFF9 (-7), B=2 -> Lo=0xFFFFFFFD (-3), Hi=0xFFFFFFFF (-1). DIVU 100/7 -> Lo=14, Hi=2.
- DIVU A=0x1234, B=0 -> Hi=0x1234, Lo=0xFFFFFFFF. Also DIV 0x80000000/0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- MTHI 0xAAAA in IDLE -> Hi=0xAAAA next cycle. Start and LoWe asserted during Busy -> both ignored, and the original result is preserved.
- rst asserted at cycle 10 of a MULT -> Hi=Lo=0, Busy=0, no Done. Start is accepted on the first cycle after rst is released.
- With MDU_DIV_EN undefined: DIV start -> Busy stays 0 and Hi/Lo are unchanged.
